ps2_key_event: RTL and testbench
================================

PS2_KEY_EVENT -- requirements
Module: ps2_key_event

Interface
REQ-001 Parameter DEPTH, default 4, sets the event FIFO entry count; it SHALL be a power of two in the range 2..16.
REQ-002 clk  input  1  single system clock; all state SHALL update on the rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  one-cycle strobe; in_data holds a received PS/2 scan byte that has already passed parity and framing checks.
REQ-005 in_data  input  8  received scan byte, sampled only when in_valid=1.
REQ-006 out_ready  input  1  consumer accepts the head event this cycle.
REQ-007 out_valid  output  1  FIFO non-empty; the head event is presented.
REQ-008 out_code  output  8  base scan code of the head event.
REQ-009 out_ext  output  1  head event was prefixed by E0.
REQ-010 out_break  output  1  head event is a release (1) or a press (0).
REQ-011 overflow  output  1  sticky; an event was dropped because the FIFO was full.
REQ-012 proto_err  output  1  sticky; an illegal prefix sequence was seen.
REQ-013 make_cnt  output  8  count of press events pushed into the FIFO.

Function
REQ-014 The input path SHALL have no backpressure; every in_valid byte SHALL be consumed in the same cycle.
REQ-015 The prefix FSM SHALL have states IDLE, GOT_E0, GOT_F0 and GOT_E0F0.
REQ-016 FSM transitions:
- IDLE, E0 -> GOT_E0.
- IDLE, F0 -> GOT_F0.
- GOT_E0, F0 -> GOT_E0F0.
- Any state, any other code -> emit an event, then return to IDLE.
REQ-017 An emitted event SHALL carry ext=1 if it came from GOT_E0 or GOT_E0F0, and brk=1 if it came from GOT_F0 or GOT_E0F0.
REQ-018 The following SHALL set proto_err and drop the byte:
- E0 received in GOT_F0 or GOT_E0F0 -> next state GOT_E0.
- F0 received in GOT_F0 or GOT_E0F0 -> state unchanged.
REQ-019 E0 received in GOT_E0 SHALL leave the state at GOT_E0 and SHALL NOT set proto_err.
REQ-020 In IDLE, the bytes 00, AA, EE, FA, FE and FF SHALL be discarded with no event and no state change.
REQ-021 Latency: if the completing byte arrives in cycle N and the FIFO is empty, out_valid SHALL be 1 in cycle N+1.
REQ-022 A pop SHALL occur when out_valid=1 and out_ready=1 in the same cycle; the outputs then show the next entry in the following cycle.
REQ-023 Push while full without a same-cycle pop: drop the event, set overflow, leave the FIFO contents unchanged.
REQ-024 Push while full with a same-cycle pop: accept the event; overflow SHALL NOT be set.
REQ-025 Push and pop in the same cycle on an empty FIFO SHALL NOT occur, because out_valid=0; the pushed event appears in the next cycle.
REQ-026 FIFO pointers SHALL wrap modulo DEPTH.
REQ-027 Occupancy SHALL be held in a log2(DEPTH)+1-bit counter.
REQ-028 make_cnt SHALL increment only on accepted press pushes and SHALL wrap from 255 to 0.
REQ-029 out_code, out_ext and out_break SHALL be 0 whenever out_valid=0.

Reset
REQ-030 resetn=0 SHALL immediately, without waiting for clk, force:
- FSM to IDLE;
- FIFO to empty;
- out_valid, out_code, out_ext, out_break, overflow, proto_err and make_cnt to 0.
REQ-031 Reset in the middle of a prefix sequence SHALL discard the partial prefix; the first byte after reset SHALL be decoded from IDLE.
REQ-032 Sticky flags SHALL clear only on reset.

Configuration
REQ-033 Macro PS2_KEY_EVENT_REPEAT_FILTER_EN compiles in the typematic-repeat filter.
REQ-034 With the macro defined:
- A held register {valid, ext, code} SHALL record the last accepted press.
- A press matching the held register SHALL be suppressed: no push, no make_cnt change.
- A release matching the held register SHALL clear its valid bit and SHALL still be pushed.
- A press with a different code or ext SHALL replace the held register.
REQ-035 Without the macro, every decoded press SHALL be pushed; the held register SHALL NOT exist.

Verification
REQ-036 Bytes 1C, F0, 1C with out_ready=1 -> events {1C, ext0, brk0} then {1C, ext0, brk1}; make_cnt=1.
REQ-037 Bytes E0, 75, E0, F0, 75 -> events {75, ext1, brk0} then {75, ext1, brk1}; proto_err=0.
REQ-038 out_ready=0 with DEPTH=4; five presses 15, 1D, 24, 2D, 2C -> 4 entries held, overflow=1, the head after release is 15, and 2C is lost.
REQ-039 Bytes F0, E0, 74 -> proto_err=1; single event {74, ext1, brk0}.
REQ-040 resetn pulsed low between E0 and 6B, then 6B sent -> single event {6B, ext0, brk0}.
REQ-041 Macro defined; bytes 1C, 1C, 1C, F0, 1C -> exactly two events (press, release); make_cnt=1.

Source files
------------

// File: rtl/ps2_key_event.sv
// ps2_key_event
//   Turns a stream of validated PS/2 scan bytes into key events. Each event
//   carries {code, ext, brk} and goes into a small FIFO.
//   A prefix FSM tracks the E0 (extended) and F0 (break) prefixes.
//
//   Optional build macro: PS2_KEY_EVENT_REPEAT_FILTER_EN
//     When defined, repeated presses of the key that is still held
//     (typematic repeat) are suppressed.
//
// Parameters
//   DEPTH      FIFO entry count. Must be a power of two, 2..16.
// Ports
//   clk        system clock, rising edge
//   resetn     asynchronous active-low reset
//   in_valid   one-cycle strobe for in_data (no backpressure)
//   in_data    received scan byte
//   out_ready  consumer pops the head event when out_valid is also high
//   out_valid  FIFO is non-empty
//   out_code   base scan code of the head event (0 when empty)
//   out_ext    head event had an E0 prefix (0 when empty)
//   out_break  head event is a release (0 when empty)
//   overflow   sticky: an event was dropped because the FIFO was full
//   proto_err  sticky: an illegal prefix sequence was seen
//   make_cnt   count of press events accepted into the FIFO (wraps)
module ps2_key_event #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_code,
    output logic       out_ext,
    output logic       out_break,
    output logic       overflow,
    output logic       proto_err,
    output logic [7:0] make_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          proto_err_q, proto_err_d;
    logic [7:0]    make_cnt_q, make_cnt_d;

    // Each entry is {ext, brk, code}.
    logic [9:0]    mem [DEPTH];

    logic ev_vld, ev_ext, ev_brk, err_set;
    logic push, pop, full, push_ok;
    logic is_junk;

    // Controller responses such as BAT ok, echo, ack and resend are not key
    // codes. They are ignored only between events, not after a prefix.
    always_comb begin
        is_junk = (in_data == 8'h00) || (in_data == 8'hAA) || (in_data == 8'hEE) ||
                  (in_data == 8'hFA) || (in_data == 8'hFE) || (in_data == 8'hFF);
    end

    // Prefix decode.
    always_comb begin
        state_d = state_q;
        ev_vld  = 1'b0;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        err_set = 1'b0;
        if (in_valid) begin
            if (in_data == 8'hE0) begin
                // E0 always lands in GOT_E0. After F0 it is out of order.
                err_set = (state_q == GOT_F0) || (state_q == GOT_E0F0);
                state_d = GOT_E0;
            end else if (in_data == 8'hF0) begin
                case (state_q)
                    IDLE:    state_d = GOT_F0;
                    GOT_E0:  state_d = GOT_E0F0;
                    default: err_set = 1'b1;
                endcase
            end else if (!(state_q == IDLE && is_junk)) begin
                ev_vld  = 1'b1;
                ev_ext  = (state_q == GOT_E0) || (state_q == GOT_E0F0);
                ev_brk  = (state_q == GOT_F0) || (state_q == GOT_E0F0);
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        full = (count_q == CW'(DEPTH));
        pop  = out_valid && out_ready;
    end

`ifdef PS2_KEY_EVENT_REPEAT_FILTER_EN
    logic       held_vld_q, held_vld_d;
    logic       held_ext_q, held_ext_d;
    logic [7:0] held_code_q, held_code_d;
    logic       held_match;

    always_comb begin
        held_match  = held_vld_q && (held_ext_q == ev_ext) && (held_code_q == in_data);
        push        = ev_vld && !(!ev_brk && held_match);
        push_ok     = push && (!full || pop);
        held_vld_d  = held_vld_q;
        held_ext_d  = held_ext_q;
        held_code_d = held_code_q;
        if (ev_vld && ev_brk && held_match) begin
            held_vld_d = 1'b0;
        end else if (push_ok && !ev_brk) begin
            held_vld_d  = 1'b1;
            held_ext_d  = ev_ext;
            held_code_d = in_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            held_vld_q  <= 1'b0;
            held_ext_q  <= 1'b0;
            held_code_q <= 8'h00;
        end else begin
            held_vld_q  <= held_vld_d;
            held_ext_q  <= held_ext_d;
            held_code_q <= held_code_d;
        end
    end
`else
    always_comb begin
        push    = ev_vld;
        push_ok = push && (!full || pop);
    end
`endif

    // FIFO and counters. A push while full is accepted only if the head is
    // leaving in the same cycle.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q || (push && full && !pop);
        proto_err_d = proto_err_q || err_set;
        make_cnt_d  = make_cnt_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 1'b1;
        end
        if (push_ok && !ev_brk) begin
            make_cnt_d = make_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
            make_cnt_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
            make_cnt_q  <= make_cnt_d;
        end
    end

    // Storage needs no reset; the head fields are masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= {ev_ext, ev_brk, in_data};
        end
    end

    logic [9:0] head;

    always_comb begin
        head      = mem[rd_ptr_q];
        out_valid = (count_q != '0);
        out_code  = out_valid ? head[7:0] : 8'h00;
        out_break = out_valid ? head[8]   : 1'b0;
        out_ext   = out_valid ? head[9]   : 1'b0;
        overflow  = overflow_q;
        proto_err = proto_err_q;
        make_cnt  = make_cnt_q;
    end

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench for ps2_key_event (DEPTH=4).
// Inputs are driven at the falling edge and sampled one half-cycle after
// each rising edge.
module tb_ps2_key_event;

    logic       clk = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_code;
    logic       out_ext;
    logic       out_break;
    logic       overflow;
    logic       proto_err;
    logic [7:0] make_cnt;

    int err_cnt = 0;
    int chk_cnt = 0;

    ps2_key_event #(.DEPTH(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .out_ext   (out_ext),
        .out_break (out_break),
        .overflow  (overflow),
        .proto_err (proto_err),
        .make_cnt  (make_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Push and pop in the same cycle.
    task automatic send_pop(input logic [7:0] b);
        out_ready = 1'b1;
        send(b);
        out_ready = 1'b0;
    endtask

    // Check the head event and pop it.
    task automatic expect_ev(input string tag, input logic [7:0] code,
                             input logic ext, input logic brk);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_code"},  32'(out_code),  32'(code));
        chk({tag, "_ext"},   32'(out_ext),   32'(ext));
        chk({tag, "_brk"},   32'(out_break), 32'(brk));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic expect_empty(input string tag);
        chk({tag, "_empty"}, 32'(out_valid), 32'd0);
        chk({tag, "_code0"}, 32'({out_ext, out_break, out_code}), 32'd0);
    endtask

    task automatic do_reset();
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_perr",  32'(proto_err), 32'd0);
        chk("async_rst_ovf",   32'(overflow),  32'd0);
        chk("async_rst_mcnt",  32'(make_cnt),  32'd0);
        #1 resetn = 1'b1;
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_code",  32'(out_code),  32'd0);
        chk("rst_ovf",   32'(overflow),  32'd0);
        chk("rst_perr",  32'(proto_err), 32'd0);
        chk("rst_mcnt",  32'(make_cnt),  32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Plain press then release; event visible one cycle after the byte.
        send(8'h1C);
        chk("lat_valid", 32'(out_valid), 32'd1);
        send(8'hF0);
        send(8'h1C);
        expect_ev("a_press", 8'h1C, 1'b0, 1'b0);
        expect_ev("a_rel",   8'h1C, 1'b0, 1'b1);
        expect_empty("a");
        chk("a_mcnt", 32'(make_cnt), 32'd1);

        // Extended press and release.
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
        expect_ev("b_press", 8'h75, 1'b1, 1'b0);
        expect_ev("b_rel",   8'h75, 1'b1, 1'b1);
        expect_empty("b");
        chk("b_perr", 32'(proto_err), 32'd0);

        // Repeated E0 is harmless.
        send(8'hE0); send(8'hE0); send(8'h75);
        expect_ev("c_ext", 8'h75, 1'b1, 1'b0);
        expect_empty("c");
        chk("c_perr", 32'(proto_err), 32'd0);

        // Controller responses in IDLE produce nothing.
        send(8'hAA); send(8'hFA); send(8'hFE); send(8'h00);
        @(negedge clk);
        expect_empty("junk");

        // E0 after F0 is a protocol error and restarts an extended code.
        send(8'hF0); send(8'hE0); send(8'h74);
        chk("d_perr", 32'(proto_err), 32'd1);
        expect_ev("d_ev", 8'h74, 1'b1, 1'b0);
        expect_empty("d");
        chk("d_mcnt", 32'(make_cnt), 32'd4);

        // F0 F0 is also an error; the second F0 is dropped.
        do_reset();
        send(8'hF0); send(8'hF0); send(8'h12);
        chk("f_perr", 32'(proto_err), 32'd1);
        expect_ev("f_ev", 8'h12, 1'b0, 1'b1);
        expect_empty("f");

        // Overflow: five presses into four entries, 2C lost.
        do_reset();
        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
        chk("o_ovf0",  32'(overflow), 32'd0);
        send(8'h2C);
        chk("o_ovf1",  32'(overflow), 32'd1);
        chk("o_mcnt",  32'(make_cnt), 32'd4);
        expect_ev("o_1", 8'h15, 1'b0, 1'b0);
        expect_ev("o_2", 8'h1D, 1'b0, 1'b0);
        expect_ev("o_3", 8'h24, 1'b0, 1'b0);
        expect_ev("o_4", 8'h2D, 1'b0, 1'b0);
        expect_empty("o");
        chk("o_ovf_sticky", 32'(overflow), 32'd1);

        // Push while full with a same-cycle pop is accepted; pointers wrap.
        do_reset();
        send(8'h11); send(8'h12); send(8'h13); send(8'h14);
        send_pop(8'h16);
        chk("p_ovf",  32'(overflow), 32'd0);
        chk("p_mcnt", 32'(make_cnt), 32'd5);
        expect_ev("p_1", 8'h12, 1'b0, 1'b0);
        expect_ev("p_2", 8'h13, 1'b0, 1'b0);
        expect_ev("p_3", 8'h14, 1'b0, 1'b0);
        expect_ev("p_4", 8'h16, 1'b0, 1'b0);
        expect_empty("p");

        // Reset between E0 and 6B discards the prefix.
        do_reset();
        send(8'hE0);
        do_reset();
        send(8'h6B);
        expect_ev("r_ev", 8'h6B, 1'b0, 1'b0);
        expect_empty("r");

        // Typematic repeat.
        do_reset();
        send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
`ifdef PS2_KEY_EVENT_REPEAT_FILTER_EN
        chk("t_mcnt", 32'(make_cnt), 32'd1);
        expect_ev("t_press", 8'h1C, 1'b0, 1'b0);
        expect_ev("t_rel",   8'h1C, 1'b0, 1'b1);
`else
        chk("t_mcnt", 32'(make_cnt), 32'd3);
        expect_ev("t_p1",  8'h1C, 1'b0, 1'b0);
        expect_ev("t_p2",  8'h1C, 1'b0, 1'b0);
        expect_ev("t_p3",  8'h1C, 1'b0, 1'b0);
        expect_ev("t_rel", 8'h1C, 1'b0, 1'b1);
`endif
        expect_empty("t");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
